// File: rtl/bm_rd_arb.sv
// ---------------------------------------------------------------------------
// bm_rd_arb -- bias memory read arbiter / write-ownership sequencer
//
// Shares the single bias memory read port between the conv and fc bias
// fetchers with round-robin arbitration. Each read return goes back to the
// requester that issued it. The d2c loader can also take exclusive write
// ownership of the memory: new reads stop, in-flight reads drain, and then
// wr_gnt is held until the loader drops wr_req.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   conv_req/addr      conv read request (held until granted) and address
//   conv_gnt           conv request accepted this cycle (combinational)
//   conv_dout/vld      conv read return (registered)
//   fc_req/addr        fc read request and address
//   fc_gnt             fc request accepted this cycle (combinational)
//   fc_dout/vld        fc read return (registered)
//   wr_req             loader asks for write ownership (level)
//   wr_gnt             loader owns the memory (registered)
//   mem_rd_en/addr     bias memory read strobe and address
//   mem_dout           bias memory read data, RD_LAT cycles after mem_rd_en
//   dbg_state          current FSM state (0=RD, 1=DRAIN, 2=WR)
//
// Handshake: a request is consumed in the cycle where req and gnt are both
// high. If req stays high after a grant, it is a new request. Each grant
// issues exactly one memory read. The read returns as a one-cycle vld pulse
// RD_LAT+1 cycles after the grant. Returns arrive in issue order.
// ---------------------------------------------------------------------------
module bm_rd_arb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 512,
    parameter int RD_LAT = 2      // legal 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_req,
    input  logic [ADDR_W-1:0] conv_addr,
    output logic              conv_gnt,
    output logic [DATA_W-1:0] conv_dout,
    output logic              conv_vld,
    input  logic              fc_req,
    input  logic [ADDR_W-1:0] fc_addr,
    output logic              fc_gnt,
    output logic [DATA_W-1:0] fc_dout,
    output logic              fc_vld,
    input  logic              wr_req,
    output logic              wr_gnt,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_RD    = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WR    = 2'd2
    } state_t;

    state_t state, state_nxt;

    // 1 when fc owned the most recent grant. Resetting to 1 lets conv win
    // the first tie.
    logic last_fc;

    // Tag pipe: stage k holds the read that was granted k+1 cycles ago.
    // Stage RD_LAT-1 lines up with the cycle where mem_dout carries that
    // read's data.
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_fc;

    logic pipe_busy;
    logic rd_ok;

    assign pipe_busy = |tag_vld;

    // ---------------- next state / grants ----------------
    always_comb begin
        state_nxt = state;
        conv_gnt  = 1'b0;
        fc_gnt    = 1'b0;
        rd_ok     = (state == ST_RD) && !wr_req;

        // A pending write blocks grants in the same cycle. Because no grant
        // is made, the pipe is empty this cycle exactly when no stage is valid.
        if (rd_ok) begin
            conv_gnt = conv_req && (!fc_req || last_fc);
            fc_gnt   = fc_req && (!conv_req || !last_fc);
        end

        case (state)
            ST_RD: begin
                if (wr_req) state_nxt = pipe_busy ? ST_DRAIN : ST_WR;
            end
            ST_DRAIN: begin
                // If the loader gives up while we drain, go back to reading
                // without ever raising wr_gnt.
                if (!wr_req)        state_nxt = ST_RD;
                else if (!pipe_busy) state_nxt = ST_WR;
            end
            ST_WR: begin
                if (!wr_req) state_nxt = ST_RD;
            end
            default: state_nxt = ST_RD;
        endcase
    end

    assign mem_rd_en   = conv_gnt | fc_gnt;
    // When there is no grant the address is a don't-care. Defaulting to
    // conv keeps this a single 2:1 mux.
    assign mem_rd_addr = fc_gnt ? fc_addr : conv_addr;
    assign dbg_state   = state;

    // ---------------- sequential ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RD;
            wr_gnt    <= 1'b0;
            last_fc   <= 1'b1;
            tag_vld   <= '0;
            tag_fc    <= '0;
            conv_vld  <= 1'b0;
            fc_vld    <= 1'b0;
            conv_dout <= '0;
            fc_dout   <= '0;
        end else begin
            state  <= state_nxt;
            // Registered straight from the next-state decode, so wr_gnt
            // stays glitch-free when the state encoding changes two bits.
            wr_gnt <= (state_nxt == ST_WR);

            if (mem_rd_en) last_fc <= fc_gnt;

            for (int i = RD_LAT - 1; i >= 1; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_fc[i]  <= tag_fc[i-1];
            end
            tag_vld[0] <= mem_rd_en;
            tag_fc[0]  <= fc_gnt;

            conv_vld <= tag_vld[RD_LAT-1] && !tag_fc[RD_LAT-1];
            fc_vld   <= tag_vld[RD_LAT-1] &&  tag_fc[RD_LAT-1];
            if (tag_vld[RD_LAT-1] && !tag_fc[RD_LAT-1]) conv_dout <= mem_dout;
            if (tag_vld[RD_LAT-1] &&  tag_fc[RD_LAT-1]) fc_dout   <= mem_dout;
        end
    end

endmodule

// File: tb/tb_bm_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_bm_rd_arb -- directed bench for bm_rd_arb.
// The bench drives grants in a fixed order and checks them directly. Each
// expected grant pushes {port, return cycle, data} onto exp_q. A negedge
// monitor pops exp_q on every vld and checks port, data and arrival cycle.
// The memory model returns addr*3 RD_LAT cycles after mem_rd_en.
// ---------------------------------------------------------------------------
module tb_bm_rd_arb;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 512;
    localparam int RD_LAT = 2;
    localparam int EW     = DATA_W + 33;   // {port_fc, cycle[31:0], data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              conv_req, fc_req, wr_req;
    logic [ADDR_W-1:0] conv_addr, fc_addr;
    logic              conv_gnt, fc_gnt, conv_vld, fc_vld, wr_gnt;
    logic [DATA_W-1:0] conv_dout, fc_dout, mem_dout;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [1:0]        dbg_state;

    bm_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .conv_req(conv_req), .conv_addr(conv_addr), .conv_gnt(conv_gnt),
        .conv_dout(conv_dout), .conv_vld(conv_vld),
        .fc_req(fc_req), .fc_addr(fc_addr), .fc_gnt(fc_gnt),
        .fc_dout(fc_dout), .fc_vld(fc_vld),
        .wr_req(wr_req), .wr_gnt(wr_gnt),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_dout(mem_dout),
        .dbg_state(dbg_state)
    );

    // ---------------- memory model ----------------
    logic [DATA_W-1:0] mpipe [RD_LAT];
    always @(posedge clk) begin
        mpipe[0] <= mem_rd_en ? DATA_W'(mem_rd_addr) * DATA_W'(3)
                              : {(DATA_W/32){32'hdead_beef}};
        for (int i = 1; i < RD_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mem_dout = mpipe[RD_LAT-1];

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (conv_vld || fc_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_vld", DATA_W'({conv_vld, fc_vld}), '0);
            end else begin
                e = exp_q.pop_front();
                check("ret_both",  DATA_W'(conv_vld & fc_vld), '0);
                check("ret_port",  DATA_W'(fc_vld), DATA_W'(e[EW-1]));
                check("ret_data",  fc_vld ? fc_dout : conv_dout, e[DATA_W-1:0]);
                check("ret_cycle", DATA_W'(cyc), DATA_W'(e[DATA_W +: 32]));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q[0];
            if (int'(e[DATA_W +: 32]) <= cyc) begin
                void'(exp_q.pop_front());
                check("missed_vld", '0, DATA_W'(1));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input bit is_fc, input logic [ADDR_W-1:0] a);
        logic [31:0] rc;
        check(is_fc ? "fc_gnt" : "conv_gnt", DATA_W'({conv_gnt, fc_gnt}),
              DATA_W'(is_fc ? 2'b01 : 2'b10));
        check("mem_rd_en", DATA_W'(mem_rd_en), DATA_W'(1));
        check("mem_rd_addr", DATA_W'(mem_rd_addr), DATA_W'(a));
        rc = 32'(cyc + RD_LAT + 1);
        exp_q.push_back({is_fc, rc, DATA_W'(a) * DATA_W'(3)});
    endtask

    task automatic expect_none(input string tag);
        check(tag, DATA_W'({conv_gnt, fc_gnt, mem_rd_en}), '0);
    endtask

    task automatic expect_fsm(input string tag, input logic [1:0] st,
                              input logic wg);
        check({tag, "_state"}, DATA_W'(dbg_state), DATA_W'(st));
        check({tag, "_wr_gnt"}, DATA_W'(wr_gnt), DATA_W'(wg));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        conv_req = 1'b0; fc_req = 1'b0; wr_req = 1'b0;
        conv_addr = '0;  fc_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_fsm("reset", 2'd0, 1'b0);
        check("reset_vld", DATA_W'({conv_vld, fc_vld}), '0);
        check("reset_conv_dout", conv_dout, '0);
        check("reset_fc_dout", fc_dout, '0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single conv reader.
        conv_req = 1'b1; conv_addr = 10'h005;
        @(negedge clk); expect_grant(1'b0, 10'h005);
        next_cycle();
        conv_req = 1'b0;
        repeat (4) begin @(negedge clk); expect_none("idle_gnt"); next_cycle(); end

        // Single fc reader; it also leaves last_owner=fc for the tie test.
        fc_req = 1'b1; fc_addr = 10'h003;
        @(negedge clk); expect_grant(1'b1, 10'h003);
        next_cycle();
        fc_req = 1'b0;
        repeat (4) next_cycle();

        // Contention: both held for 6 cycles, grants alternate starting at conv.
        conv_req = 1'b1; conv_addr = 10'h010;
        fc_req   = 1'b1; fc_addr   = 10'h020;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            expect_grant(i[0], i[0] ? 10'h020 : 10'h010);
            next_cycle();
        end
        conv_req = 1'b0; fc_req = 1'b0;
        repeat (5) next_cycle();

        // Write preemption with two reads in flight.
        conv_req = 1'b1; conv_addr = 10'h040;
        @(negedge clk); expect_grant(1'b0, 10'h040);
        next_cycle();
        conv_req = 1'b0; fc_req = 1'b1; fc_addr = 10'h041;
        @(negedge clk); expect_grant(1'b1, 10'h041);
        next_cycle();
        fc_req = 1'b0; conv_req = 1'b1; conv_addr = 10'h042; wr_req = 1'b1;
        @(negedge clk); expect_none("pre_gnt"); expect_fsm("pre_rd", 2'd0, 1'b0);
        next_cycle();
        @(negedge clk); expect_none("drain1_gnt"); expect_fsm("drain1", 2'd1, 1'b0);
        next_cycle();
        @(negedge clk); expect_none("drain2_gnt"); expect_fsm("drain2", 2'd1, 1'b0);
        next_cycle();
        @(negedge clk); expect_none("wr1_gnt"); expect_fsm("wr1", 2'd2, 1'b1);
        next_cycle();
        @(negedge clk); expect_none("wr2_gnt"); expect_fsm("wr2", 2'd2, 1'b1);
        next_cycle();
        wr_req = 1'b0;
        @(negedge clk); expect_none("wr_drop_gnt"); expect_fsm("wr_drop", 2'd2, 1'b1);
        next_cycle();
        @(negedge clk); expect_grant(1'b0, 10'h042); expect_fsm("resume", 2'd0, 1'b0);
        next_cycle();
        conv_req = 1'b0;
        repeat (4) next_cycle();

        // Immediate write on an idle pipe; conv held pending during WR.
        wr_req = 1'b1;
        @(negedge clk); expect_none("iw_gnt0"); expect_fsm("iw0", 2'd0, 1'b0);
        next_cycle();
        conv_req = 1'b1; conv_addr = 10'h055;
        @(negedge clk); expect_none("iw_gnt1"); expect_fsm("iw1", 2'd2, 1'b1);
        next_cycle();
        @(negedge clk); expect_none("iw_gnt2");
        next_cycle();
        wr_req = 1'b0;
        @(negedge clk); expect_none("iw_gnt3"); expect_fsm("iw3", 2'd2, 1'b1);
        next_cycle();
        @(negedge clk); expect_grant(1'b0, 10'h055); expect_fsm("iw4", 2'd0, 1'b0);
        next_cycle();
        conv_req = 1'b0;
        repeat (4) next_cycle();

        // Abort: wr_req pulsed for one cycle while a read is in flight.
        fc_req = 1'b1; fc_addr = 10'h066;
        @(negedge clk); expect_grant(1'b1, 10'h066);
        next_cycle();
        fc_req = 1'b0; wr_req = 1'b1; conv_req = 1'b1; conv_addr = 10'h067;
        @(negedge clk); expect_none("ab_gnt0"); expect_fsm("ab0", 2'd0, 1'b0);
        next_cycle();
        wr_req = 1'b0;
        @(negedge clk); expect_none("ab_gnt1"); expect_fsm("ab1", 2'd1, 1'b0);
        next_cycle();
        @(negedge clk); expect_grant(1'b0, 10'h067); expect_fsm("ab2", 2'd0, 1'b0);
        next_cycle();
        conv_req = 1'b0;
        repeat (5) next_cycle();

        // Reset with two reads in flight: their returns must never appear.
        conv_req = 1'b1; conv_addr = 10'h070;
        @(negedge clk); expect_grant(1'b0, 10'h070);
        next_cycle();
        conv_req = 1'b0; fc_req = 1'b1; fc_addr = 10'h071;
        @(negedge clk); expect_grant(1'b1, 10'h071);
        next_cycle();
        fc_req = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("rst_vld", DATA_W'({conv_vld, fc_vld}), '0);
            expect_fsm("rst", 2'd0, 1'b0);
            next_cycle();
        end
        rst = 1'b0;
        conv_req = 1'b1; conv_addr = 10'h072;
        fc_req   = 1'b1; fc_addr   = 10'h073;
        @(negedge clk); expect_grant(1'b0, 10'h072);
        next_cycle();
        @(negedge clk); expect_grant(1'b1, 10'h073);
        next_cycle();
        conv_req = 1'b0; fc_req = 1'b0;

        // Bounded drain of outstanding returns.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) next_cycle();
        repeat (3) next_cycle();
        check("final_queue_empty", DATA_W'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bm_rd_arb.md
Name: bm_rd_arb

Overview:
Arbiter and sequencer for the single-port bias memory (BM) read/write path. It shares one BM read port between the conv and fc engines using round-robin arbitration and routes each read return to the requester that issued it. It also gives the DRAM-to-chip loader exclusive write access: reads stop, in-flight reads drain, and the grant is held until the loader releases it. It sits between the conv/fc bias fetch logic, the d2c loader and the bias memory array.

Parameters:
ADDR_W, 10, BM address width (equals $clog2(`BM_DEPTH)).
DATA_W, 512, BM data width (equals `BM_DATA_WIDTH).
RD_LAT, 2, fixed bias-memory read latency in cycles, from mem_rd_en to valid mem_dout; legal values 1..4.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
conv_req  in  1  conv read request; held until granted.
conv_addr  in  ADDR_W  conv read address; stable while conv_req is high.
conv_gnt  out  1  conv request accepted this cycle (combinational).
conv_dout  out  DATA_W  conv read data (registered).
conv_vld  out  1  conv_dout valid (registered).
fc_req  in  1  fc read request; held until granted.
fc_addr  in  ADDR_W  fc read address.
fc_gnt  out  1  fc request accepted this cycle (combinational).
fc_dout  out  DATA_W  fc read data (registered).
fc_vld  out  1  fc_dout valid (registered).
wr_req  in  1  loader requests exclusive write ownership; level signal.
wr_gnt  out  1  loader owns the memory (registered).
mem_rd_en  out  1  BM read enable (combinational, equals conv_gnt|fc_gnt).
mem_rd_addr  out  ADDR_W  BM read address (address of the granted requester).
mem_dout  in  DATA_W  BM read data, valid RD_LAT cycles after mem_rd_en.

Behaviour:
- Reset values: state=RD, last_owner=fc (conv wins the first tie), tag pipe cleared, wr_gnt=0, conv_vld=fc_vld=0, conv_dout=fc_dout=0.
- States:
  - RD: grants are allowed.
  - DRAIN: no grants; wait for the tag pipe to empty.
  - WR: wr_gnt=1; no grants.
- Transitions:
  - RD -> WR when wr_req=1 and the tag pipe is empty (counting this cycle).
  - RD -> DRAIN when wr_req=1 and the pipe is not empty.
  - DRAIN -> WR when the pipe is empty.
  - WR -> RD when wr_req=0.
  - wr_gnt is high exactly while in state WR.
- Write priority: in RD, when wr_req=1, no grant is issued that cycle, even if conv_req or fc_req is high.
- Grant rules (RD and wr_req=0):
  - Only one requesting: that one is granted.
  - Both requesting: grant the one that is not last_owner.
  - last_owner updates on every grant.
  - At most one gnt per cycle. Back-to-back grants are allowed, so throughput is 1 read per cycle.
- Request rules: a requester whose req stays high after its grant is treated as a new request. Each grant corresponds to exactly one read.
- mem_rd_addr: the granted address. When there is no grant it holds conv_addr (don't-care for the memory).
- Tag pipe:
  - RD_LAT-stage shift register of {valid, owner}, written on each grant.
  - When stage RD_LAT-1 is valid, mem_dout is registered into the owner's dout and that owner's vld is pulsed.
  - The other port's dout holds its value and its vld is 0.
- Latency: gnt at cycle T produces vld at T+RD_LAT+1. Returns are in issue order.
- Pipe empty: no valid stage is present, and none is being written this cycle.
- Reset mid-operation: all state is cleared immediately. In-flight returns are discarded (no vld), and wr_gnt drops asynchronously.
- wr_req dropping during DRAIN: return to RD the next cycle without asserting wr_gnt.
- Requests during DRAIN or WR: they are held pending and not lost. The round-robin order resumes from last_owner.

Test Plan:
- Single reader: conv_req for 1 cycle at addr 0x005 with mem model data = addr*3 -> conv_gnt at the same cycle, mem_rd_addr=0x005; conv_vld at +3 cycles with conv_dout=0x00F; fc_vld stays 0.
- Contention: conv_req and fc_req held for 6 cycles with addresses 0x10/0x20 -> grants alternate conv, fc, conv, fc, conv, fc; returns arrive in the same order, each on the correct port, 3 cycles after its grant.
- Write preemption: 2 reads in flight, wr_req raised -> no further grants; state DRAIN; wr_gnt rises the cycle after the last vld has its pipe stage cleared; pending conv_req is granted the cycle after wr_req drops.
- Immediate write: idle pipe, wr_req=1 -> wr_gnt=1 next cycle; conv_req asserted during WR -> no conv_gnt until wr_req=0, then conv_gnt one cycle later.
- Abort: wr_req pulsed for 1 cycle while DRAIN is needed -> wr_gnt is never asserted; RD resumes the next cycle.
- Reset mid-burst: rst asserted with 2 reads in flight and wr_gnt=0 -> no vld appears afterwards; after release, the first tie goes to conv.
